// File: rtl/ei_tdp_ram_port_master.sv
// Initiator for one TDP RAM port: valid/ready commands in, registered RAM port out, in-order read data via a credit-guarded FIFO.
// Burst support (cmd_len, BURST state) is compiled in only when EI_TDP_RAM_MST_BURST_EN is defined.
module ei_tdp_ram_port_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RSP_DEPTH  = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
`ifdef EI_TDP_RAM_MST_BURST_EN
    input  logic [LEN_WIDTH-1:0]  cmd_len,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic                  run_r;
    logic                  inflight_r;
    logic [DATA_WIDTH-1:0] fifo_mem_r [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         fifo_count_r;
    logic                  credit_ok_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  burst_active_s;
    logic                  issue_we_s;
    logic                  issue_re_s;
    logic [ADDR_WIDTH-1:0] issue_addr_s;
    logic [DATA_WIDTH-1:0] issue_data_s;

    // A read may issue only if a FIFO slot remains after every read already on its way.
    assign credit_ok_s = (fifo_count_r + CW'(mem_re) + CW'(inflight_r)) < DEPTH_C;

`ifdef EI_TDP_RAM_MST_BURST_EN
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] burst_addr_r;
    logic [LEN_WIDTH-1:0]  beats_left_r;
    logic                  burst_we_r;
    logic [DATA_WIDTH-1:0] burst_data_r;

    // State register and saved context of the burst in progress
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            burst_addr_r <= '0;
            beats_left_r <= '0;
            burst_we_r   <= 1'b0;
            burst_data_r <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && cmd_valid && cmd_ready) begin
                burst_addr_r <= cmd_addr + ADDR_WIDTH'(1);
                beats_left_r <= cmd_len;
                burst_we_r   <= cmd_we;
                burst_data_r <= cmd_wdata;
            end else if (state_r == BURST && (issue_we_s || issue_re_s)) begin
                burst_addr_r <= burst_addr_r + ADDR_WIDTH'(1);
                beats_left_r <= beats_left_r - LEN_WIDTH'(1);
            end
        end
    end

    // Next state and beat selection; burst reads wait for credit, burst writes never do
    always_comb begin
        state_s      = state_r;
        cmd_ready    = 1'b0;
        issue_we_s   = 1'b0;
        issue_re_s   = 1'b0;
        issue_addr_s = cmd_addr;
        issue_data_s = cmd_wdata;
        case (state_r)
            IDLE: begin
                cmd_ready = run_r && credit_ok_s;
                if (cmd_valid && cmd_ready) begin
                    issue_we_s = cmd_we;
                    issue_re_s = !cmd_we;
                    if (cmd_len != '0) begin
                        state_s = BURST;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                issue_addr_s = burst_addr_r;
                issue_data_s = burst_data_r;
                if (burst_we_r || credit_ok_s) begin
                    issue_we_s = burst_we_r;
                    issue_re_s = !burst_we_r;
                    if (beats_left_r == LEN_WIDTH'(1)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = BURST;
                    end
                end else begin
                    state_s = BURST;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign burst_active_s = (state_r == BURST);
`else
    // Every accepted command is exactly one RAM beat
    always_comb begin
        cmd_ready    = run_r && credit_ok_s;
        issue_addr_s = cmd_addr;
        issue_data_s = cmd_wdata;
        if (cmd_valid && cmd_ready) begin
            issue_we_s = cmd_we;
            issue_re_s = !cmd_we;
        end else begin
            issue_we_s = 1'b0;
            issue_re_s = 1'b0;
        end
    end

    assign burst_active_s = 1'b0;
`endif

    // RAM port registers; addr/data hold between beats, the read tag follows mem_re by one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_r      <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            inflight_r <= 1'b0;
        end else begin
            run_r      <= 1'b1;
            mem_we     <= issue_we_s;
            mem_re     <= issue_re_s;
            inflight_r <= mem_re;
            if (issue_we_s || issue_re_s) begin
                mem_addr <= issue_addr_s;
            end
            if (issue_we_s) begin
                mem_data <= issue_data_s;
            end
        end
    end

    assign push_s = inflight_r;
    assign pop_s  = rsp_valid && rsp_ready;

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Response storage; entries are only observed after being pushed
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= mem_q;
        end
    end

    assign rsp_valid = (fifo_count_r != '0);
    assign rsp_data  = rsp_valid ? fifo_mem_r[rd_ptr_r] : '0;
    assign busy      = burst_active_s || mem_re || inflight_r || rsp_valid;

endmodule

// File: tb/tb_ei_tdp_ram_port_master.sv
// Bench for ei_tdp_ram_port_master: RAM model on the port, array+queue reference, scoreboard monitor.
`timescale 1ns/1ps
module tb_ei_tdp_ram_port_master;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
`ifdef EI_TDP_RAM_MST_BURST_EN
    logic [LW-1:0] cmd_len = '0;
`endif
    logic          rsp_ready = 1'b0;
    logic          cmd_ready, rsp_valid, mem_we, mem_re, busy;
    logic [DW-1:0] rsp_data, mem_data;
    logic [DW-1:0] mem_q = '0;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int failures = 0;
    int rsp_cnt = 0;
    int rr_mode = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] ram [1<<AW];
    bit ram_ready = 1'b0;

    ei_tdp_ram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(4), .LEN_WIDTH(LW)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef EI_TDP_RAM_MST_BURST_EN
        .cmd_len(cmd_len),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_re(mem_re),
        .mem_q(mem_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM port: preloaded with the low address byte, registered q.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
            ram_ready = 1'b1;
        end
        if (mem_we) ram[mem_addr] = mem_data;
        if (mem_re) mem_q <= ram[mem_addr];
    end

    initial forever begin
        @(negedge clk);
        rsp_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // Scoreboard monitor: every handshake pops one expected word.
    initial forever begin
        logic [DW-1:0] e;
        @(negedge clk);
        #2;
        checks++;
        if (mem_we && mem_re) begin
            failures++;
            $display("FAIL we_re_exclusive got=both_high required=at_most_one t=%0t", $time);
        end
        if (rsp_valid && rsp_ready) begin
            checks++;
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp got=%02h required=none t=%0t", rsp_data, $time);
            end else begin
                e = exp_q.pop_front();
                if (rsp_data !== e) begin
                    failures++;
                    $display("FAIL rsp_data got=%02h required=%02h t=%0t", rsp_data, e, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int len);
        logic [AW-1:0] ai;
        for (int i = 0; i <= len; i++) begin
            ai = a + AW'(i);
            if (we) ref_mem[ai] = d;
            else exp_q.push_back(ref_mem[ai]);
        end
    endtask

    task automatic try_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int len, output bit acc);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_addr = a;
        cmd_wdata = d;
`ifdef EI_TDP_RAM_MST_BURST_EN
        cmd_len = LW'(len);
`endif
        #4;
        acc = cmd_ready;
        @(posedge clk);
        if (acc) model_cmd(we, a, d, len);
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int len);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            try_cmd(we, a, d, len, acc);
            tries++;
        end
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        int nacc;
        int base;
        int len;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i % 256);

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        #2;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write then read back with 2-cycle latency
        send(1'b1, AW'(16'h010), 8'hA5, 0);
        send(1'b0, AW'(16'h010), 8'h00, 0);
        idle();
        #2;
        chk("lat_cycle0_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #2;
        chk("lat_cycle1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #2;
        chk("lat_cycle2_valid", 32'(rsp_valid), 32'd1);
        chk("lat_cycle2_data", 32'(rsp_data), 32'hA5);

        // Eight back-to-back reads at full rate
        repeat (2) @(negedge clk);
        base = rsp_cnt;
        for (int i = 0; i < 8; i++) send(1'b0, AW'(i), 8'h00, 0);
        idle();
        repeat (2) @(negedge clk);
        #3;
        chk("b2b_rsp_count", 32'(rsp_cnt - base), 32'd8);
        drain();

        // Response backpressure: only RSP_DEPTH reads accepted
        rr_mode = 1;
        repeat (2) @(negedge clk);
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            try_cmd(1'b0, AW'(16'h040 + nacc), 8'h00, 0, acc);
            if (acc) nacc++;
        end
        chk("full_accepts", 32'(nacc), 32'd4);
        @(negedge clk);
        #4;
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        rr_mode = 0;
        for (int j = nacc; j < 8; j++) send(1'b0, AW'(16'h040 + j), 8'h00, 0);
        idle();
        drain();

        // Reset while reads are pending
        rr_mode = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) send(1'b0, AW'(16'h060 + i), 8'h00, 0);
        idle();
        repeat (3) @(negedge clk);
        #3;
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_mem_re", 32'(mem_re), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b1;
        rr_mode = 0;
        repeat (10) @(negedge clk);
        #3;
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);

`ifdef EI_TDP_RAM_MST_BURST_EN
        // Wrapping burst write, then burst read under random backpressure
        send(1'b1, AW'(16'h3FE), 8'h5C, 3);
        rr_mode = 2;
        send(1'b0, AW'(16'h3FE), 8'h00, 3);
        send(1'b0, AW'(16'h3FF), 8'h00, 0);
        send(1'b0, AW'(16'h001), 8'h00, 0);
        idle();
        rr_mode = 0;
        drain();
`endif

        // Randomized mixed traffic
        rr_mode = 2;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
`ifdef EI_TDP_RAM_MST_BURST_EN
                len = int'($urandom_range(0, 3));
`else
                len = 0;
`endif
                send(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 31)), DW'($urandom), len);
            end
        end
        idle();
        rr_mode = 0;
        drain();
        repeat (3) @(negedge clk);
        #3;
        chk("final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
